// File: rtl/tone_synth.sv
// Multi-channel square-wave tone generator: one command port loads or stops
// per-channel notes; each channel toggles its output every div+1 cycles for dur cycles.
module tone_synth #(
  parameter int CH    = 4,
  parameter int DIV_W = 17,
  parameter int DUR_W = 24,
  parameter int CW    = (CH > 1) ? $clog2(CH) : 1,
  localparam int MW   = $clog2(CH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CW-1:0]    cmd_ch,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [DUR_W-1:0] cmd_dur,
  output logic [CH-1:0]    sound,
  output logic [CH-1:0]    busy,
  output logic [CH-1:0]    done,
  output logic [MW-1:0]    mix
);

  typedef enum logic {IDLE, PLAY} state_t;

  function automatic logic [MW-1:0] popcnt(input logic [CH-1:0] v);
    logic [MW-1:0] c;
    c = '0;
    for (int i = 0; i < CH; i++) c = c + MW'(v[i]);
    return c;
  endfunction

  logic ch_ok;
  logic busy_sel;
  logic [MW-1:0] mix_p1;

  assign ch_ok = (int'(cmd_ch) < CH);

  always_comb begin
    busy_sel = 1'b0;
    for (int i = 0; i < CH; i++)
      if (cmd_ch == CW'(i)) busy_sel = busy[i];
  end

  // Out-of-range channels are always ready and simply match no channel below.
  assign cmd_ready = (cmd_dur == '0) || !ch_ok || !busy_sel;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           st, st_nxt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DUR_W-1:0] dur_q;
    logic             snd_p0, done_p0;
    logic             sel, play_acc, stop_acc, expire;

    assign sel      = cmd_valid && cmd_ready && (cmd_ch == CW'(i));
    assign play_acc = sel && (cmd_dur != '0);
    assign stop_acc = sel && (cmd_dur == '0);
    assign expire   = (st == PLAY) && (dur_q == DUR_W'(1));

    always_comb begin
      st_nxt = st;
      case (st)
        IDLE: if (play_acc) st_nxt = PLAY;
        PLAY: if (stop_acc || expire) st_nxt = IDLE;
        default: st_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) st <= IDLE;
      else     st <= st_nxt;
    end

    // Stage 0: tone divider, duration count and the done pulse
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q   <= '0;
        dur_q   <= '0;
        snd_p0  <= 1'b0;
        done_p0 <= 1'b0;
      end else begin
        done_p0 <= expire && !stop_acc;
        if (st == IDLE) begin
          if (play_acc) begin
            div_q  <= cmd_div;
            dur_q  <= cmd_dur;
            cnt_q  <= '0;
            snd_p0 <= 1'b0;
          end
        end else if (stop_acc || expire) begin
          cnt_q  <= '0;
          dur_q  <= '0;
          snd_p0 <= 1'b0;
        end else begin
          dur_q <= dur_q - DUR_W'(1);
          if (cnt_q == div_q) begin
            cnt_q  <= '0;
            snd_p0 <= !snd_p0;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
      end
    end

    assign sound[i] = snd_p0;
    assign busy[i]  = (st == PLAY);
    assign done[i]  = done_p0;
  end

  // Stage 1: mixer count of the registered square waves
  always_ff @(posedge clk) begin
    if (rst) mix_p1 <= '0;
    else     mix_p1 <= popcnt(sound);
  end

  assign mix = mix_p1;

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: a cycle-level note model checked every cycle,
// directed scenarios with literal expectations, then randomized command traffic.
module tb_tone_synth;
  localparam int CH    = 5;
  localparam int DIV_W = 17;
  localparam int DUR_W = 24;
  localparam int CW    = 3;
  localparam int MW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CW-1:0]    cmd_ch = '0;
  logic [DIV_W-1:0] cmd_div = '0;
  logic [DUR_W-1:0] cmd_dur = '0;
  logic [CH-1:0]    sound, busy, done;
  logic [MW-1:0]    mix;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  tone_synth #(.CH(CH), .DIV_W(DIV_W), .DUR_W(DUR_W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_div(cmd_div), .cmd_dur(cmd_dur),
    .sound(sound), .busy(busy), .done(done), .mix(mix)
  );

  always #5 clk = ~clk;

  // Note model: a playing channel is described by elapsed cycles k since accept,
  // note length n and half-period dv+1; the wave is the parity of k/(dv+1).
  int m_act[CH];
  int m_k[CH];
  int m_n[CH];
  int m_dv[CH];
  bit m_dn[CH];
  int m_mix = 0;

  function automatic bit m_snd(int c);
    return (m_act[c] != 0) && (((m_k[c] / (m_dv[c] + 1)) % 2) == 1);
  endfunction

  function automatic bit m_ready();
    if (cmd_dur == '0 || int'(cmd_ch) >= CH) return 1'b1;
    return m_act[int'(cmd_ch)] == 0;
  endfunction

  always @(posedge clk) begin
    int pc;
    bit acc;
    acc = cmd_valid && m_ready();
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_act[c] = 0; m_k[c] = 0; m_dn[c] = 1'b0;
      end
      m_mix = 0;
    end else begin
      pc = 0;
      for (int c = 0; c < CH; c++) pc += int'(m_snd(c));
      m_mix = pc;
      for (int c = 0; c < CH; c++) begin
        m_dn[c] = 1'b0;
        if (m_act[c] != 0) begin
          m_k[c]++;
          if (m_k[c] == m_n[c]) begin
            m_act[c] = 0;
            m_dn[c]  = 1'b1;
          end
        end
      end
      if (acc && int'(cmd_ch) < CH) begin
        if (cmd_dur == '0) begin
          m_act[int'(cmd_ch)] = 0;
          m_dn[int'(cmd_ch)]  = 1'b0;
        end else begin
          m_act[int'(cmd_ch)] = 1;
          m_k[int'(cmd_ch)]   = 0;
          m_n[int'(cmd_ch)]   = int'(cmd_dur);
          m_dv[int'(cmd_ch)]  = int'(cmd_div);
        end
      end
    end
  end

  task automatic check(string nm, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [CH-1:0] es, eb, ed;
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        es[c] = m_snd(c);
        eb[c] = (m_act[c] != 0);
        ed[c] = m_dn[c];
      end
      check("model_sound", 32'(sound), 32'(es));
      check("model_busy",  32'(busy),  32'(eb));
      check("model_done",  32'(done),  32'(ed));
      check("model_mix",   32'(mix),   32'(m_mix));
      check("model_ready", 32'(cmd_ready), 32'(m_ready()));
    end
  end

  // Inputs for the next rising edge; outputs read after this return show the
  // state produced by the edge that consumed the previous call's inputs.
  task automatic cmd(bit v, int ch, int dv, int du);
    @(negedge clk);
    #2;
    cmd_valid = v;
    cmd_ch    = CW'(ch);
    cmd_div   = DIV_W'(dv);
    cmd_dur   = DUR_W'(du);
  endtask

  task automatic idle();
    cmd(1'b0, 0, 0, 0);
  endtask

  initial begin
    logic [11:0] pat;
    int bcnt;

    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_sound", 32'(sound), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_mix",   32'(mix), 0);
    #1 check("rst_ready", 32'(cmd_ready), 1);
    #1 rst = 1'b0;

    // Single note, div=2 dur=12
    cmd(1'b1, 0, 2, 12);
    pat = '0; bcnt = 0;
    for (int j = 0; j < 12; j++) begin
      idle();
      pat  = {pat[10:0], sound[0]};
      bcnt += int'(busy[0]);
    end
    check("note_pattern", 32'(pat), 32'h1c7);
    check("note_busy_cycles", bcnt, 12);
    idle();
    check("note_done", 32'(done[0]), 1);
    check("note_idle_busy", 32'(busy[0]), 0);
    check("note_idle_sound", 32'(sound[0]), 0);
    idle();
    check("note_done_one_cycle", 32'(done[0]), 0);

    // Busy channel refuses a play, a free one takes it
    cmd(1'b1, 1, 3, 100);
    cmd(1'b1, 1, 3, 5);
    #1 check("busy_ch_ready", 32'(cmd_ready), 0);
    cmd(1'b1, 2, 3, 5);
    #1 check("free_ch_ready", 32'(cmd_ready), 1);
    idle();
    check("two_busy", 32'(busy), 32'b00110);
    cmd(1'b1, 1, 0, 0);
    cmd(1'b1, 2, 0, 0);
    idle();
    check("stopped_busy", 32'(busy), 0);

    // Stop a long note mid-way
    cmd(1'b1, 0, 0, 1000);
    for (int j = 0; j < 49; j++) idle();
    cmd(1'b1, 0, 0, 0);
    idle();
    check("stop_busy", 32'(busy[0]), 0);
    check("stop_sound", 32'(sound[0]), 0);
    check("stop_no_done", 32'(done[0]), 0);
    idle();
    check("stop_no_done2", 32'(done[0]), 0);

    // Four div=0 channels started on even offsets run in phase
    for (int c = 0; c < 4; c++) begin
      cmd(1'b1, c, 0, 300);
      if (c < 3) idle();
    end
    for (int j = 0; j < 6; j++) begin
      idle();
      check("phase_sound", 32'(sound[3:0]), (j % 2 == 1) ? 32'hf : 32'h0);
      if (j > 0) check("phase_mix", 32'(mix), (j % 2 == 0) ? 4 : 0);
    end
    for (int c = 0; c < 4; c++) cmd(1'b1, c, 0, 0);
    idle();

    // Reset mid-note, with a command pending during reset
    cmd(1'b1, 3, 5, 40);
    for (int j = 0; j < 20; j++) idle();
    check("pre_rst_busy", 32'(busy[3]), 1);
    @(negedge clk); #2;
    rst = 1'b1; cmd_valid = 1'b1; cmd_ch = 0; cmd_div = 1; cmd_dur = 5;
    @(negedge clk);
    check("midrst_all", 32'({sound, busy, done, 2'b00, mix}), 0);
    #2 rst = 1'b0; cmd_valid = 1'b0;
    #1 check("post_rst_ready", 32'(cmd_ready), 1);
    idle();
    check("rst_discard", 32'(busy), 0);
    check("rst_no_done", 32'(done), 0);

    // Stop coincides with natural expiry
    cmd(1'b1, 0, 1, 10);
    for (int j = 0; j < 9; j++) idle();
    cmd(1'b1, 0, 0, 0);
    #1 check("coinc_still_busy", 32'(busy[0]), 1);
    idle();
    check("coinc_busy", 32'(busy[0]), 0);
    check("coinc_no_done", 32'(done[0]), 0);
    idle();
    check("coinc_no_done2", 32'(done[0]), 0);

    // Out-of-range channel commands are accepted and ignored
    cmd(1'b1, 0, 1, 10);
    cmd(1'b1, 7, 3, 20);
    #1 check("oor_ready", 32'(cmd_ready), 1);
    cmd(1'b1, 6, 0, 0);
    idle();
    check("oor_no_effect", 32'(busy), 32'b00001);
    cmd(1'b1, 0, 0, 0);

    // Back-to-back restart on the done cycle
    cmd(1'b1, 2, 1, 3);
    for (int j = 0; j < 3; j++) idle();
    cmd(1'b1, 2, 1, 4);
    check("b2b_done", 32'(done[2]), 1);
    #1 check("b2b_ready", 32'(cmd_ready), 1);
    idle();
    check("b2b_busy", 32'(busy[2]), 1);
    for (int j = 0; j < 5; j++) idle();

    // Randomized traffic
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk); #2;
      rst       = ($urandom_range(0, 399) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_ch    = CW'($urandom_range(0, 7));
      cmd_div   = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 400))
                                              : DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0)       cmd_dur = '0;
      else if ($urandom_range(0, 20) == 0) cmd_dur = DUR_W'($urandom_range(100, 1000));
      else                                 cmd_dur = DUR_W'($urandom_range(1, 40));
    end
    @(negedge clk); #2 rst = 1'b0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
